async_fifo_burst_writer: RTL
============================

// Module: async_fifo_burst_writer
// PURPOSE
//  Write-side producer for the dual-clock FIFO. Sits in the wr_clk domain.
//  Takes a valid/ready packet stream and drives the FIFO write port (wr_en/wr_data) under fifo_full back-pressure.
//  Pads every packet up to a whole burst of BURST_LEN words, so the rd_clk side always pops whole bursts.
// PARAMETERS
//  DATA_WIDTH  8      width of stream data and FIFO word
//  BURST_LEN   4      words per burst; power of 2, >=2
//  PAD_VALUE   8'hA5  word written for padding beats (DATA_WIDTH wide)
//  CNT_WIDTH   16     width of pkt_cnt and stall_cnt
// PORTS
//  wr_clk     in   1           write-domain clock
//  wr_rst_n   in   1           reset, asynchronous, active-low
//  s_valid    in   1           upstream word valid
//  s_data     in   DATA_WIDTH  upstream word
//  s_last     in   1           final word of packet
//  s_ready    out  1           upstream accept; transfer = s_valid & s_ready at wr_clk edge
//  fifo_full  in   1           FIFO full flag (write domain)
//  wr_en      out  1           FIFO write enable
//  wr_data    out  DATA_WIDTH  FIFO write data
//  burst_done out  1           1-cycle pulse after final word of each burst is written
//  pkt_cnt    out  CNT_WIDTH   packets fully written, incl. padding; wraps
//  stall_cnt  out  CNT_WIDTH   cycles with a word pending and fifo_full=1; saturates
// BEHAVIOUR
//  - Reset: state=DATA, hold_vld=0, beat_cnt=0, wr_en=0, wr_data=0, burst_done=0, pkt_cnt=0, stall_cnt=0.
//    s_ready is forced 0 while wr_rst_n=0.
//  - One-entry hold register: hold_vld, hold_data, hold_last.
//  - beat fires = wr_en at a wr_clk edge.
//  - wr_en = (hold_vld | state==PAD) & !fifo_full. This is combinational on fifo_full.
//  - wr_data = (state==PAD) ? PAD_VALUE : hold_data.
//  - s_ready = (state==DATA) & (!hold_vld | !fifo_full).
//    Accept and beat in the same edge is allowed, so throughput is 1 word/clk.
//  - Latency: word accepted at edge k drives wr_en/wr_data in cycle k+1 and is written at edge k+1 if not full.
//  - fifo_full=1: wr_en=0, hold contents and wr_data stable, no word dropped or duplicated.
//  - beat_cnt ($clog2(BURST_LEN) bits) increments on every beat and wraps BURST_LEN-1 -> 0.
//  - FSM DATA -> PAD: on a beat with hold_last=1 and beat_cnt != BURST_LEN-1.
//  - FSM DATA -> DATA: on a last beat with beat_cnt == BURST_LEN-1. No padding; pkt_cnt+1.
//  - FSM PAD -> DATA: on the pad beat with beat_cnt == BURST_LEN-1. pkt_cnt+1.
//  - PAD state: s_ready=0; pad beats issue back-to-back unless fifo_full=1.
//  - burst_done is registered: high the cycle after any beat with beat_cnt == BURST_LEN-1.
//  - Packets longer than BURST_LEN span multiple bursts; only the final burst is padded.
//  - Reset mid-packet or mid-PAD: partial burst is abandonned and the next word starts at beat_cnt=0.
//    The system must reset the rd_clk side together with this block.
// CONFIGURATION
//  ASYNC_FIFO_WR_STALL_CNT_EN defined:
//    - stall_cnt increments each cycle with (hold_vld | state==PAD) & fifo_full.
//    - stall_cnt saturates at all-ones.
//  ASYNC_FIFO_WR_STALL_CNT_EN undefined:
//    - stall_cnt is tied to 0 and no counter logic is built.
// STRUCTURE
//  - Package async_fifo_pkg holds:
//    - FSM state encoding localparams ST_DATA=1'b0, ST_PAD=1'b1.
//    - default PAD_VALUE constant.
//    - shared CNT_WIDTH default.
//  - One sub-module: async_fifo_wr_hold (hold register + s_ready/wr_en handshake).
//  - Top level keeps the FSM, beat_cnt and counters.
// TESTING (BURST_LEN=4, PAD_VALUE=8'hA5, fifo_full=0 unless stated)
//  1 Packet 01,02,03,04(last)
//      -> wr_en high 4 consecutive cycles, data 01..04, no pad.
//      -> burst_done pulses once; pkt_cnt=1.
//  2 Packet 11,12(last)
//      -> FIFO receives 11,12,A5,A5.
//      -> s_ready=0 for the 2 PAD cycles; pkt_cnt=1.
//  3 Packet of 5 words 21..25
//      -> FIFO receives 21..25 then A5,A5,A5 (8 words).
//      -> burst_done pulses twice.
//  4 fifo_full=1 for 5 cycles while 32 is held
//      -> wr_en=0 and wr_data=32 for all 5 cycles, s_ready=0.
//      -> 32 written once after release; stall_cnt=5 with the macro, 0 without.
//  5 Reset asserted during second PAD beat of scenario 2
//      -> all outputs return to reset values immediately.
//      -> next packet 41(last) gives 41,A5,A5,A5.
//  6 Two back-to-back packets, s_valid held high
//      -> 1 word/clk sustained, no gap between packets that end on a burst boundary.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO write-side blocks.
//   ST_DATA / ST_PAD : burst writer FSM state encoding
//   DEF_PAD_VALUE    : default filler word for padding beats
//   DEF_CNT_WIDTH    : default width of the packet/stall counters
package async_fifo_pkg;

    localparam logic ST_DATA = 1'b0;
    localparam logic ST_PAD  = 1'b1;

    localparam logic [7:0]  DEF_PAD_VALUE = 8'hA5;
    localparam int unsigned DEF_CNT_WIDTH = 16;

endpackage

// File: rtl/async_fifo_wr_hold.sv
// One-entry hold register between the upstream valid/ready stream and the FIFO
// write port. Owns the s_ready / wr_en handshake.
// Ports:
//   clk, rst_n          write clock, asynchronous active-low reset
//   s_valid/s_data/s_last/s_ready  upstream stream
//   fifo_full           FIFO full flag
//   pad                 writer is issuing padding beats (blocks upstream, keeps hold)
//   wr_en               FIFO write enable (combinational on fifo_full)
//   hold_vld/hold_data/hold_last   current hold contents
module async_fifo_wr_hold #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  fifo_full,
    input  logic                  pad,
    output logic                  wr_en,
    output logic                  hold_vld,
    output logic [DATA_WIDTH-1:0] hold_data,
    output logic                  hold_last
);

    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  accept;
    logic                  pop;

    assign wr_en   = (vld_q | pad) & ~fifo_full;
    // Reset gates s_ready so nothing is handshaken while the block is held in reset.
    assign s_ready = rst_n & ~pad & (~vld_q | ~fifo_full);
    assign accept  = s_valid & s_ready;
    // Pad beats write the filler word, so they must not consume the held word.
    assign pop     = wr_en & ~pad;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        last_d = last_q;
        if (accept) begin
            vld_d  = 1'b1;
            data_d = s_data;
            last_d = s_last;
        end else if (pop) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            last_q <= last_d;
        end
    end

    assign hold_vld  = vld_q;
    assign hold_data = data_q;
    assign hold_last = last_q;

endmodule

// File: rtl/async_fifo_burst_writer.sv
// Write-side producer for the dual-clock FIFO (wr_clk domain). Forwards a
// valid/ready packet stream into the FIFO write port under fifo_full
// back-pressure and pads every packet to a whole burst of BURST_LEN words.
// Ports:
//   wr_clk, wr_rst_n    write clock, asynchronous active-low reset
//   s_valid/s_data/s_last/s_ready  upstream packet stream
//   fifo_full           FIFO full flag
//   wr_en, wr_data      FIFO write port
//   burst_done          pulse the cycle after the last word of a burst is written
//   pkt_cnt             packets fully written including padding (wraps)
//   stall_cnt           stalled cycles (saturating); built only when
//                       ASYNC_FIFO_WR_STALL_CNT_EN is defined, else tied to 0
module async_fifo_burst_writer
    import async_fifo_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 8,
    parameter int unsigned          BURST_LEN  = 4,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE = DATA_WIDTH'(DEF_PAD_VALUE),
    parameter int unsigned          CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  fifo_full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  burst_done,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN);

    logic                  state_q, state_d;
    logic [BEAT_W-1:0]     beat_cnt_q;
    logic                  burst_done_q;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic                  pad;
    logic                  beat;
    logic                  beat_is_end;
    logic                  hold_vld;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_last;

    assign pad = (state_q == ST_PAD);

    async_fifo_wr_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hold (
        .clk       (wr_clk),
        .rst_n     (wr_rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .fifo_full (fifo_full),
        .pad       (pad),
        .wr_en     (wr_en),
        .hold_vld  (hold_vld),
        .hold_data (hold_data),
        .hold_last (hold_last)
    );

    assign beat        = wr_en;
    assign beat_is_end = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
    assign wr_data     = pad ? PAD_VALUE : hold_data;

    always_comb begin
        state_d   = state_q;
        pkt_cnt_d = pkt_cnt_q;
        if (beat) begin
            if (!pad) begin
                if (hold_last) begin
                    // A last word on the burst boundary completes the packet directly.
                    if (beat_is_end) pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
                    else             state_d   = ST_PAD;
                end
            end else if (beat_is_end) begin
                state_d   = ST_DATA;
                pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q      <= ST_DATA;
            beat_cnt_q   <= '0;
            burst_done_q <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pkt_cnt_q    <= pkt_cnt_d;
            burst_done_q <= beat & beat_is_end;
            if (beat) beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
        end
    end

    assign burst_done = burst_done_q;
    assign pkt_cnt    = pkt_cnt_q;

`ifdef ASYNC_FIFO_WR_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            stall_cnt_q <= '0;
        end else if ((hold_vld | pad) & fifo_full & ~(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
